booth_operand_feeder: RTL and testbench

Upstream operand sequencer for the sequential Booth multiply-accumulate unit. Accepts signed operand pairs over a valid/ready stream and buffers them in a small FIFO. Presents one pair at a time to the MAC, holding operands and enable stable for the whole multi-cycle transaction, and retires each pair on the MAC's one-cycle ready pulse. Tracks completed products and flags completion of a tagged vector end.

---
 rtl/booth_pkg.sv | 17 +
 rtl/booth_operand_fifo.sv | 59 +++++
 rtl/booth_operand_feeder.sv | 140 ++++++++++++++
 tb/tb_booth_operand_feeder.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared definitions for the Booth MAC and its operand feeder: default operand width,
// sequencer state encoding and the packed FIFO entry width.
package booth_pkg;

    localparam int unsigned DEFAULT_OPERAND_WIDTH = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } booth_state_e;

    // One FIFO entry packs {a, b, last}
    function automatic int unsigned entry_width(input int unsigned op_w);
        return 2 * op_w + 1;
    endfunction

endpackage

// File: rtl/booth_operand_fifo.sv
// Synchronous FIFO holding operand pairs; exposes the head and the entry behind it
// so the sequencer can reload on the same edge it retires the head.
module booth_operand_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [WIDTH-1:0]         head_next,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    next_idx;
    logic             do_push, do_pop;

    // Extra pointer bit distinguishes full from empty
    assign count     = wr_ptr_q - rd_ptr_q;
    assign full      = (count == PW'(DEPTH));
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign next_idx  = rd_ptr_q[AW-1:0] + AW'(1);
    assign head      = mem_q[rd_ptr_q[AW-1:0]];
    assign head_next = mem_q[next_idx];

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/booth_operand_feeder.sv
// Operand sequencer for the sequential Booth MAC: buffers signed pairs and issues them one
// transaction at a time. Optional zero-operand skipping via BOOTH_FEED_ZERO_SKIP_EN.
module booth_operand_feeder
    import booth_pkg::*;
#(
    parameter int unsigned OPERAND_WIDTH = DEFAULT_OPERAND_WIDTH,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned CNT_WIDTH     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPERAND_WIDTH-1:0] in_a,
    input  logic [OPERAND_WIDTH-1:0] in_b,
    input  logic                     in_last,
    output logic                     mul_en,
    output logic [OPERAND_WIDTH-1:0] mul_a,
    output logic [OPERAND_WIDTH-1:0] mul_b,
    input  logic                     mul_ready,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_WIDTH-1:0]     retired_cnt
);

    localparam int unsigned EW = entry_width(OPERAND_WIDTH);
    localparam int unsigned PW = $clog2(FIFO_DEPTH) + 1;

    booth_state_e             state_q, state_d;
    logic [OPERAND_WIDTH-1:0] mul_a_q, mul_a_d;
    logic [OPERAND_WIDTH-1:0] mul_b_q, mul_b_d;
    logic                     last_q, last_d;
    logic                     done_q, done_d;
    logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;

    logic                     fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [EW-1:0]            head, head_next;
    logic [PW-1:0]            fifo_count;
    logic [OPERAND_WIDTH-1:0] head_a, head_b, next_a, next_b;
    logic                     head_last, next_last;
    logic                     head_skip, next_skip;

    assign fifo_push = in_valid && !fifo_full;
    assign {head_a, head_b, head_last} = head;
    assign {next_a, next_b, next_last} = head_next;

    booth_operand_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .wdata     ({in_a, in_b, in_last}),
        .pop       (fifo_pop),
        .head      (head),
        .head_next (head_next),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

`ifdef BOOTH_FEED_ZERO_SKIP_EN
    assign head_skip = (head_a == '0) || (head_b == '0);
    assign next_skip = (next_a == '0) || (next_b == '0);
`else
    assign head_skip = 1'b0;
    assign next_skip = 1'b0;
`endif

    // Sequencer: head stays in the FIFO while in flight and is popped on mul_ready
    always_comb begin
        state_d  = state_q;
        mul_a_d  = mul_a_q;
        mul_b_d  = mul_b_q;
        last_d   = last_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    if (head_skip) begin
                        fifo_pop = 1'b1;
                        cnt_d    = cnt_q + CNT_WIDTH'(1);
                        done_d   = head_last;
                    end else begin
                        mul_a_d = head_a;
                        mul_b_d = head_b;
                        last_d  = head_last;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (mul_ready) begin
                    fifo_pop = 1'b1;
                    cnt_d    = cnt_q + CNT_WIDTH'(1);
                    done_d   = last_q;
                    // A zero-operand successor is left for IDLE to drop
                    if ((fifo_count > PW'(1)) && !next_skip) begin
                        mul_a_d = next_a;
                        mul_b_d = next_b;
                        last_d  = next_last;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mul_a_q <= '0;
            mul_b_q <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            last_q  <= last_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready    = !fifo_full;
    assign mul_en      = (state_q == ST_RUN);
    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign busy        = (state_q == ST_RUN) || !fifo_empty;
    assign done        = done_q;
    assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_booth_operand_feeder.sv
// Scoreboard bench for booth_operand_feeder with a behavioural multi-cycle MAC model.
module tb_booth_operand_feeder;

    localparam int unsigned OW    = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [OW-1:0] in_a, in_b;
    logic          in_last;
    logic          mul_en;
    logic [OW-1:0] mul_a, mul_b;
    logic          mul_ready;
    logic          busy;
    logic          done;
    logic [CW-1:0] retired_cnt;

    booth_operand_feeder #(
        .OPERAND_WIDTH (OW),
        .FIFO_DEPTH    (DEPTH),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_last     (in_last),
        .mul_en      (mul_en),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_ready   (mul_ready),
        .busy        (busy),
        .done        (done),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    int          done_pulses = 0;
    bit          mac_on = 1'b0;
    int          mac_lat = 3;
    int          lat_cnt = 0;
    int          acc = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic bit skip_model(input logic [OW-1:0] a, input logic [OW-1:0] b);
`ifdef BOOTH_FEED_ZERO_SKIP_EN
        return (a == '0) || (b == '0);
`else
        return (a == a) && (b == b) && 1'b0;
`endif
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Offer one pair; enqueue the expected issue only when the handshake happens
    task automatic push_pair(input logic [OW-1:0] a, input logic [OW-1:0] b, input logic last,
                             input int budget, output bit ok);
        ok = 1'b0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_last = last;
        for (int t = 0; t < budget && !ok; t++) begin
            if (in_ready) begin
                ok = 1'b1;
                if (!skip_model(a, b)) exp_q.push_back({a, b});
            end
            step();
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < budget && !seen; t++) begin
            if (done) seen = 1'b1;
            else step();
        end
        check(name, seen, 1);
    endtask

    // MAC model: counts enabled cycles, pulses ready and accumulates the product
    initial begin
        logic signed [OW-1:0] sa, sb;
        mul_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                mul_ready = 1'b0;
                lat_cnt = 0;
            end else if (mac_on) begin
                if (mul_ready) begin
                    mul_ready = 1'b0;
                    lat_cnt = 0;
                end
                if (mul_en) begin
                    lat_cnt++;
                    if (lat_cnt >= mac_lat) begin
                        mul_ready = 1'b1;
                        sa = mul_a;
                        sb = mul_b;
                        acc += int'(sa) * int'(sb);
                    end
                end
            end
        end
    end

    // Monitor: every retiring transaction is compared against the scoreboard head
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && mul_en && mul_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL issue_unexpected: actual a=%h b=%h required none", mul_a, mul_b);
                end else begin
                    e = exp_q.pop_front();
                    check("issue_a", mul_a, e[31:16]);
                    check("issue_b", mul_b, e[15:0]);
                end
            end
            if (done) done_pulses++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int d0, bad, gaps;
        bit fin;

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_last = 1'b0;
        step();
        step();
        check("rst_in_ready", in_ready, 1);
        check("rst_mul_en", mul_en, 0);
        check("rst_mul_a", mul_a, 0);
        check("rst_mul_b", mul_b, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cnt", retired_cnt, 0);
        rst_n = 1'b1;
        step();

        // Single pair 3 * -5
        mac_on = 1'b1;
        acc = 0;
        d0 = done_pulses;
        push_pair(16'd3, 16'hFFFB, 1'b1, 4, ok);
        in_valid = 1'b0;
        check("t1_accept", ok, 1);
        check("t1_en_not_yet", mul_en, 0);
        step();
        check("t1_en_rise", mul_en, 1);
        bad = 0;
        fin = 1'b0;
        for (int t = 0; t < 50 && !fin; t++) begin
            if (done) fin = 1'b1;
            else begin
                if (mul_en && (mul_a !== 16'd3 || mul_b !== 16'hFFFB)) bad++;
                step();
            end
        end
        check("t1_done_seen", fin, 1);
        check("t1_stable", bad, 0);
        check("t1_cnt", retired_cnt, 1);
        check("t1_acc", acc, -15);
        step();
        check("t1_done_one_cycle", done, 0);
        check("t1_done_pulses", done_pulses - d0, 1);

        // Four pairs back-to-back
        acc = 0;
        d0 = done_pulses;
        push_pair(16'd1, 16'd2, 1'b0, 4, ok);
        push_pair(16'd3, 16'd4, 1'b0, 4, ok);
        push_pair(16'd5, 16'd6, 1'b0, 4, ok);
        push_pair(16'd7, 16'd8, 1'b1, 4, ok);
        in_valid = 1'b0;
        check("t2_accept4", ok, 1);
        check("t2_full", in_ready, 0);
        gaps = 0;
        fin = 1'b0;
        for (int t = 0; t < 200 && !fin; t++) begin
            if (done) fin = 1'b1;
            else begin
                if (!mul_en) gaps++;
                step();
            end
        end
        check("t2_done_seen", fin, 1);
        check("t2_all_issued_before_done", exp_q.size(), 0);
        check("t2_gaps", gaps, 0);
        check("t2_cnt", retired_cnt, 5);
        check("t2_acc", acc, 100);
        step();
        check("t2_done_pulses", done_pulses - d0, 1);

        // Backpressure with the MAC stalled
        mac_on = 1'b0;
        acc = 0;
        d0 = done_pulses;
        push_pair(-16'sd2, 16'sd3, 1'b0, 4, ok);
        push_pair(16'sd4, -16'sd5, 1'b0, 4, ok);
        push_pair(16'sd6, 16'sd7, 1'b0, 4, ok);
        push_pair(16'sd8, 16'sd9, 1'b0, 4, ok);
        check("t3_fill", ok, 1);
        check("t3_full", in_ready, 0);
        push_pair(-16'sd10, -16'sd11, 1'b1, 6, ok);
        check("t3_blocked", ok, 0);
        lat_cnt = 0;
        mac_on = 1'b1;
        push_pair(-16'sd10, -16'sd11, 1'b1, 100, ok);
        in_valid = 1'b0;
        check("t3_accept5", ok, 1);
        wait_done("t3_done_seen", 200);
        check("t3_cnt", retired_cnt, 10);
        check("t3_acc", acc, 198);
        check("t3_queue_empty", exp_q.size(), 0);
        step();
        check("t3_idle", busy, 0);
        check("t3_done_pulses", done_pulses - d0, 1);

        // Stray ready while idle
        mac_on = 1'b0;
        d0 = done_pulses;
        mul_ready = 1'b1;
        step();
        mul_ready = 1'b0;
        step();
        step();
        check("t4_cnt", retired_cnt, 10);
        check("t4_busy", busy, 0);
        check("t4_done", done_pulses - d0, 0);

        // Reset during the second of three transactions
        lat_cnt = 0;
        mac_on = 1'b1;
        push_pair(16'd1, 16'd1, 1'b0, 4, ok);
        push_pair(16'd2, 16'd2, 1'b0, 4, ok);
        push_pair(16'd3, 16'd3, 1'b1, 4, ok);
        in_valid = 1'b0;
        fin = 1'b0;
        for (int t = 0; t < 100 && !fin; t++) begin
            if (retired_cnt == 8'd11) fin = 1'b1;
            else step();
        end
        check("t5_first_retired", fin, 1);
        step();
        check("t5_second_in_flight", mul_en, 1);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        d0 = done_pulses;
        check("t5_in_ready", in_ready, 1);
        check("t5_mul_en", mul_en, 0);
        check("t5_mul_a", mul_a, 0);
        check("t5_mul_b", mul_b, 0);
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        check("t5_cnt", retired_cnt, 0);
        step();
        step();
        rst_n = 1'b1;
        repeat (6) step();
        check("t5_no_done", done_pulses - d0, 0);
        check("t5_still_empty", busy, 0);
        check("t5_cnt_after", retired_cnt, 0);

        // Zero operands
        acc = 0;
        d0 = done_pulses;
        push_pair(16'd0, 16'd9, 1'b0, 4, ok);
        push_pair(16'd2, 16'd0, 1'b0, 4, ok);
        push_pair(16'd4, 16'd5, 1'b1, 4, ok);
        in_valid = 1'b0;
        wait_done("t6_done_seen", 200);
        check("t6_cnt", retired_cnt, 3);
        check("t6_acc", acc, 20);
        check("t6_queue_empty", exp_q.size(), 0);
        step();
        check("t6_done_pulses", done_pulses - d0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
